// File: rtl/ad7928_spi_responder.sv
// AD7928 ADC emulation as an SPI slave, oversampling the SPI pins in the clk domain.
// Define AD7928_RESP_SEQ_EN to compile in the channel sequencer.
module ad7928_spi_responder #(
    parameter int NUM_DUMMY   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [95:0] ch_data,
    output logic [11:0] cfg_reg,
    output logic [2:0]  cur_ch,
    output logic        init_done,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int DW = (NUM_DUMMY < 2) ? 1 : $clog2(NUM_DUMMY);
    localparam logic [DW-1:0] DUMMY_LAST = DW'((NUM_DUMMY > 0) ? NUM_DUMMY - 1 : 0);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;

    logic [1:0]    r_state;
    logic [4:0]    r_edge_cnt;
    logic [15:0]   r_tx;
    logic [11:0]   r_rx;
    logic          r_miso;
    logic          r_oe;
    logic [11:0]   r_cfg;
    logic [2:0]    r_cur_ch;
    logic          r_init_done;
    logic [DW-1:0] r_dummy_cnt;
    logic          r_frame_done;
    logic          r_frame_err;
`ifdef AD7928_RESP_SEQ_EN
    logic          r_seq_on;
    logic [2:0]    r_seq_last;
`endif

    logic        w_cs;
    logic        w_sclk;
    logic        w_mosi;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_sclk_fall;
    logic [11:0] w_ch [8];
    logic [11:0] w_sample;
    logic [11:0] w_sample_coded;

    // Pins idle with CS and SCLK high, so no spurious edges appear out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '1;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b1;
        end else begin
            r_cs_sync[0]   <= spi_cs;
            r_sclk_sync[0] <= spi_sclk;
            r_mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            assign w_ch[gi] = ch_data[12*gi +: 12];
        end
    endgenerate

    assign w_sample       = w_ch[r_cur_ch];
    assign w_sample_coded = r_cfg[0] ? w_sample : {~w_sample[11], w_sample[10:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_edge_cnt   <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_cfg        <= '0;
            r_cur_ch     <= '0;
            r_init_done  <= (NUM_DUMMY == 0);
            r_dummy_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef AD7928_RESP_SEQ_EN
            r_seq_on     <= 1'b0;
            r_seq_last   <= '0;
`endif
        end else begin
            r_oe         <= ~w_cs;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_tx       <= {1'b0, r_cur_ch, w_sample_coded};
                        r_edge_cnt <= '0;
                        r_miso     <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // CS rise takes priority over an SCLK fall seen in the same cycle.
                    if (w_cs_rise) begin
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_sclk_fall) begin
                        r_edge_cnt <= r_edge_cnt + 5'd1;
                        // Only frame bits 15..4 carry control fields; the rest are dropped.
                        if (r_edge_cnt < 5'd12) begin
                            r_rx <= {r_rx[10:0], w_mosi};
                        end
                        if (r_edge_cnt == 5'd15) begin
                            r_miso  <= 1'b0;
                            r_state <= ST_HOLD;
                        end else begin
                            r_miso <= r_tx[14];
                            r_tx   <= {r_tx[14:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    r_miso <= 1'b0;
                    if (w_cs_rise) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                        if (!r_init_done) begin
                            if (r_dummy_cnt == DUMMY_LAST) begin
                                r_init_done <= 1'b1;
                            end
                            r_dummy_cnt <= r_dummy_cnt + 1'b1;
                        end else if (r_rx[11]) begin
                            r_cfg    <= r_rx;
                            r_cur_ch <= r_rx[8:6];
`ifdef AD7928_RESP_SEQ_EN
                            if (r_rx[10] && !r_rx[3]) begin
                                r_seq_on   <= 1'b1;
                                r_seq_last <= r_rx[8:6];
                                r_cur_ch   <= 3'd0;
                            end else if (!r_rx[10]) begin
                                r_seq_on <= 1'b0;
                            end
`endif
                        end
`ifdef AD7928_RESP_SEQ_EN
                        else if (r_seq_on) begin
                            r_cur_ch <= (r_cur_ch == r_seq_last) ? 3'd0 : r_cur_ch + 3'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_miso  <= 1'b0;
                end
            endcase
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign cfg_reg     = r_cfg;
    assign cur_ch      = r_cur_ch;
    assign init_done   = r_init_done;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ad7928_spi_responder.sv
// Bench for ad7928_spi_responder: randomized AD7928 frames against a rule-level model.
// Honours AD7928_RESP_SEQ_EN the same way as the design.
module tb_ad7928_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [95:0] ch_data = '0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [11:0] cfg_reg;
    logic [2:0]  cur_ch;
    logic        init_done;
    logic        frame_done;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept in terms of the ADC's documented behaviour.
    logic [11:0] m_cfg;
    logic [2:0]  m_ch;
    int          m_dummy_left;
    bit          m_seq_on;
    logic [2:0]  m_seq_last;

    ad7928_spi_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_cs      (spi_cs),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .ch_data     (ch_data),
        .cfg_reg     (cfg_reg),
        .cur_ch      (cur_ch),
        .init_done   (init_done),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cfg        = '0;
        m_ch         = '0;
        m_dummy_left = 2;
        m_seq_on     = 0;
        m_seq_last   = '0;
    endfunction

    function automatic logic [15:0] model_dout(input logic [95:0] data);
        logic [11:0] s;
        s = data[m_ch*12 +: 12];
        if (m_cfg[0] == 1'b0) s[11] = ~s[11];
        return {1'b0, m_ch, s};
    endfunction

    function automatic void model_commit(input logic [15:0] din);
        if (m_dummy_left > 0) begin
            m_dummy_left = m_dummy_left - 1;
        end else if (din[15]) begin
            m_cfg = din[15:4];
            m_ch  = din[12:10];
`ifdef AD7928_RESP_SEQ_EN
            if (din[14] && !din[7]) begin
                m_seq_on   = 1;
                m_seq_last = din[12:10];
                m_ch       = 3'd0;
            end else if (!din[14]) begin
                m_seq_on = 0;
            end
`endif
        end
`ifdef AD7928_RESP_SEQ_EN
        else if (m_seq_on) begin
            m_ch = (m_ch == m_seq_last) ? 3'd0 : m_ch + 3'd1;
        end
`endif
    endfunction

    // One master frame; optionally aborted early, or with the CS rise landing on the last SCLK fall.
    task automatic do_frame(input logic [15:0] din, input int n_edges, input bit simul_end,
                            output logic [15:0] dout, output int n_done, output int n_err,
                            output bit oe_seen);
        dout   = '0;
        n_done = 0;
        n_err  = 0;
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        oe_seen = spi_miso_oe;
        ch_data = {$urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            spi_mosi = din[16-k];
            repeat (8) @(negedge clk);
            dout[16-k] = spi_miso;
            spi_sclk = 1'b0;
            if (simul_end && k == n_edges) begin
                spi_cs = 1'b1;
            end else begin
                repeat (8) @(negedge clk);
                spi_sclk = 1'b1;
            end
        end
        if (!simul_end) begin
            repeat (8) @(negedge clk);
            spi_cs = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_done += int'(frame_done);
            n_err  += int'(frame_err);
        end
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++; if (spi_miso !== 1'b0)     begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        n_checks++; if (spi_miso_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
        n_checks++; if (cfg_reg !== 12'h000)   begin n_fail++; $display("FAIL reset_cfg: got %h want 000", cfg_reg); end
        n_checks++; if (cur_ch !== 3'd0)       begin n_fail++; $display("FAIL reset_ch: got %0d want 0", cur_ch); end
        n_checks++; if (init_done !== 1'b0)    begin n_fail++; $display("FAIL reset_init: got %b want 0", init_done); end
        n_checks++; if (frame_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_checks++; if (frame_err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
        $display("reset: outputs checked");
    endtask

    task automatic test_dummy();
        logic [15:0] dout, exp;
        int nd, ne;
        bit oe;
        for (int f = 0; f < 2; f++) begin
            ch_data = {$urandom, $urandom, $urandom};
            exp = model_dout(ch_data);
            do_frame(16'hFFFF, 16, 0, dout, nd, ne, oe);
            model_commit(16'hFFFF);
            n_checks++; if (dout !== exp)     begin n_fail++; $display("FAIL dummy_dout: got %h want %h", dout, exp); end
            n_checks++; if (nd !== 1)         begin n_fail++; $display("FAIL dummy_done: got %0d want 1", nd); end
            n_checks++; if (cfg_reg !== 12'h000) begin n_fail++; $display("FAIL dummy_cfg: got %h want 000", cfg_reg); end
            n_checks++; if (init_done !== (f == 1)) begin n_fail++; $display("FAIL dummy_init: got %b want %b", init_done, f == 1); end
            n_checks++; if (oe !== 1'b1)      begin n_fail++; $display("FAIL dummy_oe: got %b want 1", oe); end
            $display("dummy frame %0d: dout=%h init_done=%b", f, dout, init_done);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] dout;
        int nd, ne;
        bit oe;
        do_frame(16'h9710, 16, 0, dout, nd, ne, oe);
        model_commit(16'h9710);
        n_checks++; if (cfg_reg !== 12'h971) begin n_fail++; $display("FAIL wr_cfg: got %h want 971", cfg_reg); end
        n_checks++; if (cur_ch !== 3'd5)     begin n_fail++; $display("FAIL wr_ch: got %0d want 5", cur_ch); end
        $display("write 9710: cfg=%h ch=%0d", cfg_reg, cur_ch);
        ch_data[5*12 +: 12] = 12'hABC;
        do_frame(16'h0000, 16, 0, dout, nd, ne, oe);
        model_commit(16'h0000);
        n_checks++; if (dout !== 16'h5ABC)   begin n_fail++; $display("FAIL rd_binary: got %h want 5ABC", dout); end
        $display("read binary: dout=%h", dout);
    endtask

    task automatic test_twos();
        logic [15:0] dout;
        int nd, ne;
        bit oe;
        do_frame(16'h9700, 16, 0, dout, nd, ne, oe);
        model_commit(16'h9700);
        n_checks++; if (cfg_reg !== 12'h970) begin n_fail++; $display("FAIL twos_cfg: got %h want 970", cfg_reg); end
        ch_data[5*12 +: 12] = 12'h800;
        do_frame(16'h0000, 16, 0, dout, nd, ne, oe);
        model_commit(16'h0000);
        n_checks++; if (dout !== 16'h5000)   begin n_fail++; $display("FAIL rd_twos: got %h want 5000", dout); end
        $display("read twos: dout=%h", dout);
    endtask

    task automatic test_abort();
        logic [15:0] dout, exp;
        int nd, ne;
        bit oe;
        do_frame(16'h8C10, 8, 0, dout, nd, ne, oe);
        n_checks++; if (ne !== 1)          begin n_fail++; $display("FAIL abort_err: got %0d want 1", ne); end
        n_checks++; if (nd !== 0)          begin n_fail++; $display("FAIL abort_done: got %0d want 0", nd); end
        n_checks++; if (cfg_reg !== m_cfg) begin n_fail++; $display("FAIL abort_cfg: got %h want %h", cfg_reg, m_cfg); end
        n_checks++; if (cur_ch !== m_ch)   begin n_fail++; $display("FAIL abort_ch: got %0d want %0d", cur_ch, m_ch); end
        $display("abort after 8 edges: err=%0d done=%0d", ne, nd);
        do_frame(16'h8C10, 16, 1, dout, nd, ne, oe);
        n_checks++; if (ne !== 1)          begin n_fail++; $display("FAIL simul_err: got %0d want 1", ne); end
        n_checks++; if (cur_ch !== m_ch)   begin n_fail++; $display("FAIL simul_ch: got %0d want %0d", cur_ch, m_ch); end
        $display("cs rise on edge 16: err=%0d done=%0d", ne, nd);
        ch_data = {$urandom, $urandom, $urandom};
        exp = model_dout(ch_data);
        do_frame(16'h0000, 16, 0, dout, nd, ne, oe);
        model_commit(16'h0000);
        n_checks++; if (dout !== exp)      begin n_fail++; $display("FAIL post_abort_dout: got %h want %h", dout, exp); end
        n_checks++; if (nd !== 1)          begin n_fail++; $display("FAIL post_abort_done: got %0d want 1", nd); end
        $display("post-abort frame: dout=%h", dout);
    endtask

    task automatic test_sequencer();
        logic [15:0] dout, exp;
        logic [2:0]  fields [4];
        int nd, ne;
        bit oe;
`ifdef AD7928_RESP_SEQ_EN
        fields = '{3'd0, 3'd1, 3'd2, 3'd0};
`else
        fields = '{3'd2, 3'd2, 3'd2, 3'd2};
`endif
        do_frame(16'hC810, 16, 0, dout, nd, ne, oe);
        model_commit(16'hC810);
        for (int f = 0; f < 4; f++) begin
            ch_data = {$urandom, $urandom, $urandom};
            exp = model_dout(ch_data);
            do_frame(16'h0000, 16, 0, dout, nd, ne, oe);
            model_commit(16'h0000);
            n_checks++; if (dout[14:12] !== fields[f]) begin n_fail++; $display("FAIL seq_field%0d: got %0d want %0d", f, dout[14:12], fields[f]); end
            n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL seq_dout%0d: got %h want %h", f, dout, exp); end
            $display("sequencer frame %0d: dout=%h", f, dout);
        end
    endtask

    task automatic test_random();
        logic [15:0] din, dout, exp;
        int nd, ne, edges;
        bit oe;
        for (int f = 0; f < 24; f++) begin
            din   = 16'($urandom);
            edges = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            ch_data = {$urandom, $urandom, $urandom};
            exp = model_dout(ch_data);
            do_frame(din, edges, 0, dout, nd, ne, oe);
            if (edges == 16) begin
                model_commit(din);
                n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL rnd_dout%0d: got %h want %h", f, dout, exp); end
            end
            n_checks++; if (nd !== int'(edges == 16)) begin n_fail++; $display("FAIL rnd_done%0d: got %0d want %0d", f, nd, edges == 16); end
            n_checks++; if (ne !== int'(edges != 16)) begin n_fail++; $display("FAIL rnd_err%0d: got %0d want %0d", f, ne, edges != 16); end
            n_checks++; if (cfg_reg !== m_cfg) begin n_fail++; $display("FAIL rnd_cfg%0d: got %h want %h", f, cfg_reg, m_cfg); end
            n_checks++; if (cur_ch !== m_ch)   begin n_fail++; $display("FAIL rnd_ch%0d: got %0d want %0d", f, cur_ch, m_ch); end
            $display("random frame %0d: din=%h edges=%0d dout=%h cfg=%h ch=%0d", f, din, edges, dout, cfg_reg, cur_ch);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] dout, exp;
        int nd, ne;
        bit oe;
        do_frame(16'h8C10, 16, 0, dout, nd, ne, oe);
        model_commit(16'h8C10);
        n_checks++; if (cur_ch !== m_ch) begin n_fail++; $display("FAIL pre_rst_ch: got %0d want %0d", cur_ch, m_ch); end
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            repeat (8) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (8) @(negedge clk);
            spi_sclk = 1'b1;
        end
        reset_n = 1'b0;
        #1;
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe: got %b want 0", spi_miso_oe); end
        n_checks++; if (cur_ch !== 3'd0)      begin n_fail++; $display("FAIL midrst_ch: got %0d want 0", cur_ch); end
        n_checks++; if (cfg_reg !== 12'h000)  begin n_fail++; $display("FAIL midrst_cfg: got %h want 000", cfg_reg); end
        n_checks++; if (init_done !== 1'b0)   begin n_fail++; $display("FAIL midrst_init: got %b want 0", init_done); end
        $display("reset mid-frame: oe=%b ch=%0d", spi_miso_oe, cur_ch);
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            ch_data = {$urandom, $urandom, $urandom};
            exp = model_dout(ch_data);
            do_frame(16'h9710, 16, 0, dout, nd, ne, oe);
            model_commit(16'h9710);
            n_checks++; if (dout !== exp)    begin n_fail++; $display("FAIL postrst_dout%0d: got %h want %h", f, dout, exp); end
            n_checks++; if (cfg_reg !== 12'h000) begin n_fail++; $display("FAIL postrst_cfg%0d: got %h want 000", f, cfg_reg); end
            n_checks++; if (init_done !== (f == 1)) begin n_fail++; $display("FAIL postrst_init%0d: got %b want %b", f, init_done, f == 1); end
            $display("post-reset dummy %0d: dout=%h init_done=%b", f, dout, init_done);
        end
    endtask

    initial begin
        model_reset();
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_dummy();
        test_write_read();
        test_twos();
        test_abort();
        test_sequencer();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
